alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Iterative multiply/divide unit for the pipelined ARM core, sitting beside the single-cycle ALU in the Execute stage.
- Performs UMULL, SMULL, UDIV and SDIV on N-bit operands with one shift-add or shift-subtract step per cycle.
- Raises Busy so hazard logic stalls Fetch/Decode/Execute, and pulses Done when results and flags are valid.

Parameters:
N, 32, operand width; even, >= 4. Iteration count equals N.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
StartE  in  1  request; accepted only when Busy=0
MulDivOpE  in  2  00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV
FlushE  in  1  synchronous abort of the operation in flight
a  in  N  multiplicand / dividend
b  in  N  multiplier / divisor
Busy  out  1  high in RUN and DONE states
Done  out  1  one-cycle pulse; ResultHi/ResultLo/MulDivFlags valid
ResultLo  out  N  product low half / quotient
ResultHi  out  N  product high half / remainder
MulDivFlags  out  4  {N,Z,C,V}; C and V always 0
DivZero  out  1  set with Done when a divide had b==0

Behaviour:
- Reset (async, any state): state IDLE; Busy=0, Done=0, DivZero=0, ResultLo=0, ResultHi=0, MulDivFlags=0.
- States and transitions:
  - IDLE -> RUN: on the edge where StartE=1. At that edge the unit latches operand magnitudes, sign info and op, and sets count=N.
  - RUN: one iteration per edge, count decrements; on the edge where count reaches 0, -> DONE.
  - DONE: Done=1 for exactly one cycle; next edge -> IDLE.
- Latency: accept at edge 0; iterations at edges 1..N; Done high in the cycle after edge N. Back-to-back start is possible at the first IDLE cycle.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 2N-bit accumulator.
  - SMULL negates the 2N-bit result when sign(a) XOR sign(b).
  - UMULL treats operands as unsigned.
- Divide:
  - Restoring shift-subtract on magnitudes; quotient truncates toward zero.
  - SDIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - 0x80..0 / 0xFF..F yields quotient 0x80..0 and remainder 0; no trap.
- Divide by zero (b==0 for UDIV or SDIV):
  - IDLE -> DONE directly at the accepting edge; Done is high in the cycle after edge 0.
  - ResultLo=0, ResultHi=a, DivZero=1.
- Flags:
  - Multiply: N = bit 2N-1 of the product; Z = whole 2N-bit product ==0.
  - Divide: N = ResultLo[N-1]; Z = (ResultLo==0).
  - MulDivFlags[1:0] = 00 always.
- Output holding: result registers, flags and DivZero update only on entry to DONE and hold until the next DONE or reset. DivZero clears on the next accepted start.
- StartE while Busy=1 is ignored, with no queuing.
- FlushE:
  - In RUN: -> IDLE at the next edge; no Done; outputs keep their previous values.
  - In DONE: the Done pulse still completes.
  - FlushE in IDLE has no effect.
  - FlushE and StartE on the same IDLE edge: the start is not accepted.
- MulDivOpE and operands are sampled only at the accepting edge; later changes are ignored.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_t enum (UMULL, SMULL, UDIV, SDIV).
  - muldiv_state_t enum (IDLE, RUN, DONE).
  - FLAG_N/FLAG_Z/FLAG_C/FLAG_V bit-index constants.
- Sub-module muldiv_step (combinational, parametrised N) performs one iteration:
  - Multiply: conditional add and right shift of the 2N-bit accumulator.
  - Divide: trial subtract, restore, and left shift of the remainder/quotient pair.
- The top level owns the FSM, counter, sign pre/post-processing and output registers.

Test Plan:
1. UMULL a=0xFFFFFFFF b=0xFFFFFFFF, N=32 -> Done high only in the cycle after edge 32; ResultHi=0xFFFFFFFE, ResultLo=0x00000001; flags N=1 Z=0 C=0 V=0.
2. SMULL a=0xFFFFFFFD (-3) b=0x00000007 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFEB; N=1. Then SMULL a=0 b=0x1234 -> result 0, Z=1.
3. SDIV a=0xFFFFFFF9 (-7) b=2 -> ResultLo=0xFFFFFFFD, ResultHi=0xFFFFFFFF. Then SDIV 0x80000000 / 0xFFFFFFFF -> ResultLo=0x80000000, ResultHi=0, N=1.
4. UDIV a=5 b=0 -> Done in the cycle after the accepting edge; ResultLo=0, ResultHi=5, DivZero=1. Next UDIV 100/7 -> DivZero=0, ResultLo=14, ResultHi=2 after N cycles.
5. Start UMULL, hold StartE=1 through RUN with different operands, then FlushE at edge 10 -> no second accept; IDLE at edge 11; Done never pulses; results equal the previous operation's.
6. Assert reset mid-RUN (count=17) -> Busy, Done, DivZero, results and flags go to 0 immediately without a clock edge. A new start after deassertion completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and flag layout for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_UMULL = 2'b00,
        OP_SMULL = 2'b01,
        OP_UDIV  = 2'b10,
        OP_SDIV  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } muldiv_state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Pack {N,Z,C,V}; carry and overflow are never produced by this unit.
    function automatic logic [3:0] mk_flags(input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int unsigned N = 32
) (
    input  logic           i_is_div,
    input  logic [2*N-1:0] i_acc,
    input  logic [N-1:0]   i_opnd,
    output logic [2*N-1:0] o_acc_c
);
    localparam int unsigned W2 = 2 * N;

    logic [N:0] w_sum;
    logic [N:0] w_trial;
    logic [N:0] w_diff;

    // Multiply: acc = {partial_hi, multiplier_lo}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        w_sum   = {1'b0, i_acc[W2-1:N]} + {1'b0, i_opnd};
        w_trial = {i_acc[W2-1:N], i_acc[N-1]};
        w_diff  = w_trial - {1'b0, i_opnd};
        o_acc_c = '0;
        if (i_is_div) begin
            if (!w_diff[N]) begin
                o_acc_c = {w_diff[N-1:0], i_acc[N-2:0], 1'b1};
            end else begin
                o_acc_c = {w_trial[N-1:0], i_acc[N-2:0], 1'b0};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc_c = {w_sum, i_acc[N-1:1]};
            end else begin
                o_acc_c = {1'b0, i_acc[W2-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative UMULL/SMULL/UDIV/SDIV unit: FSM, iteration counter, sign handling, result registers.
module alu_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StartE,
    input  logic [1:0]   MulDivOpE,
    input  logic         FlushE,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] ResultLo,
    output logic [N-1:0] ResultHi,
    output logic [3:0]   MulDivFlags,
    output logic         DivZero
);
    localparam int unsigned W2 = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    muldiv_state_t  r_state;
    muldiv_op_t     r_op;
    logic [CW-1:0]  r_count;
    logic [W2-1:0]  r_acc;
    logic [N-1:0]   r_opnd;
    logic           r_neg_res;
    logic           r_neg_rem;

    muldiv_op_t     w_op;
    logic           w_is_div;
    logic           w_sa;
    logic           w_sb;
    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic           w_div0;
    logic           w_run_div;
    logic [W2-1:0]  w_step_acc;
    logic [W2-1:0]  w_prod;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;

    // Operand magnitudes and sign bookkeeping at the accepting edge.
    always_comb begin
        w_op     = muldiv_op_t'(MulDivOpE);
        w_is_div = MulDivOpE[1];
        w_sa     = MulDivOpE[0] & a[N-1];
        w_sb     = MulDivOpE[0] & b[N-1];
        w_mag_a  = w_sa ? (~a + N'(1)) : a;
        w_mag_b  = w_sb ? (~b + N'(1)) : b;
        w_div0   = w_is_div & (b == '0);
    end

    assign w_run_div = (r_op == OP_UDIV) || (r_op == OP_SDIV);

    muldiv_step #(.N(N)) u_step (
        .i_is_div (w_run_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc_c  (w_step_acc)
    );

    // Sign post-processing of the final iteration's accumulator.
    always_comb begin
        w_prod = r_neg_res ? (~w_step_acc + W2'(1)) : w_step_acc;
        w_quo  = r_neg_res ? (~w_step_acc[N-1:0] + N'(1)) : w_step_acc[N-1:0];
        w_rem  = r_neg_rem ? (~w_step_acc[W2-1:N] + N'(1)) : w_step_acc[W2-1:N];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_UMULL;
            r_count     <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            ResultLo    <= '0;
            ResultHi    <= '0;
            MulDivFlags <= '0;
            DivZero     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (StartE && !FlushE) begin
                        r_op      <= w_op;
                        r_neg_res <= w_sa ^ w_sb;
                        r_neg_rem <= w_sa;
                        r_count   <= CW'(N);
                        Busy      <= 1'b1;
                        DivZero   <= 1'b0;
                        if (w_div0) begin
                            r_state     <= S_DONE;
                            Done        <= 1'b1;
                            ResultLo    <= '0;
                            ResultHi    <= a;
                            DivZero     <= 1'b1;
                            MulDivFlags <= mk_flags(1'b0, 1'b1);
                        end else begin
                            r_state <= S_RUN;
                            r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                            r_acc   <= {N'(0), (w_is_div ? w_mag_a : w_mag_b)};
                        end
                    end
                end
                S_RUN: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        r_acc   <= w_step_acc;
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= S_DONE;
                            Done    <= 1'b1;
                            if (w_run_div) begin
                                ResultLo    <= w_quo;
                                ResultHi    <= w_rem;
                                MulDivFlags <= mk_flags(w_quo[N-1], w_quo == '0);
                            end else begin
                                {ResultHi, ResultLo} <= w_prod;
                                MulDivFlags <= mk_flags(w_prod[W2-1], w_prod == '0);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with an arithmetic reference model.
module tb_alu_muldiv_seq;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          StartE = 1'b0;
    logic [1:0]    MulDivOpE = 2'b00;
    logic          FlushE = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          Busy;
    logic          Done;
    logic [N-1:0]  ResultLo;
    logic [N-1:0]  ResultHi;
    logic [3:0]    MulDivFlags;
    logic          DivZero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_muldiv_seq #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .StartE      (StartE),
        .MulDivOpE   (MulDivOpE),
        .FlushE      (FlushE),
        .a           (a),
        .b           (b),
        .Busy        (Busy),
        .Done        (Done),
        .ResultLo    (ResultLo),
        .ResultHi    (ResultHi),
        .MulDivFlags (MulDivFlags),
        .DivZero     (DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;
        logic        dz;
    } res_t;

    // Plain-arithmetic reference result for one operation.
    function automatic res_t model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        longint      sx;
        longint      sy;
        longint      q;
        longint      rm;
        logic [63:0] p;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        r.dz = 1'b0;
        p    = '0;
        case (op)
            2'b00: p = {32'b0, x} * {32'b0, y};
            2'b01: p = 64'(sx * sy);
            default: begin
                if (y == 32'd0) begin
                    r.dz = 1'b1;
                    p    = {x, 32'b0};
                end else if (op == 2'b10) begin
                    p = {x % y, x / y};
                end else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    p  = {32'(rm), 32'(q)};
                end
            end
        endcase
        r.lo = p[31:0];
        r.hi = p[63:32];
        if (op[1]) r.fl = {r.lo[31], r.lo == 32'd0, 2'b00};
        else       r.fl = {p[63], p == 64'd0, 2'b00};
        return r;
    endfunction

    // Cycle-level expectation: latency bookkeeping plus the arithmetic model.
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   m_left = 0;
    res_t m_out  = '{32'd0, 32'd0, 4'd0, 1'b0};
    res_t m_pend = '{32'd0, 32'd0, 4'd0, 1'b0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_out  = '{32'd0, 32'd0, 4'd0, 1'b0};
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (FlushE) begin
                m_busy = 1'b0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_out  = m_pend;
                end
            end
        end else if (StartE && !FlushE) begin
            m_pend    = model(MulDivOpE, a, b);
            m_busy    = 1'b1;
            m_out.dz  = 1'b0;
            if (m_pend.dz) begin
                m_done = 1'b1;
                m_out  = m_pend;
            end else begin
                m_left = N;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 64'(Busy), 64'(m_busy));
            chk("cyc_done", 64'(Done), 64'(m_done));
            chk("cyc_lo", 64'(ResultLo), 64'(m_out.lo));
            chk("cyc_hi", 64'(ResultHi), 64'(m_out.hi));
            chk("cyc_flags", 64'(MulDivFlags), 64'(m_out.fl));
            chk("cyc_divzero", 64'(DivZero), 64'(m_out.dz));
        end
    end

    // Issue one operation, wait (bounded) for Done, check latency and literal results.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit lit, input logic [31:0] elo, input logic [31:0] ehi,
                          input logic [3:0] efl, input logic edz, input int elat, input bit flush_done);
        int lat;
        bit seen;
        @(posedge clk); #2;
        StartE = 1'b1; MulDivOpE = op; a = x; b = y;
        @(posedge clk); #2;
        StartE = 1'b0; MulDivOpE = ~op; a = $urandom; b = $urandom;
        if (flush_done && elat == 0) FlushE = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
            lat++;
        end
        FlushE = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_latency"}, 64'(lat), 64'(elat));
            if (lit) begin
                chk({tag, "_lo"}, 64'(ResultLo), 64'(elo));
                chk({tag, "_hi"}, 64'(ResultHi), 64'(ehi));
                chk({tag, "_flags"}, 64'(MulDivFlags), 64'(efl));
                chk({tag, "_divzero"}, 64'(DivZero), 64'(edz));
            end
        end
    endtask

    int done_cnt;

    initial begin
        #1 reset = 1'b1;
        #3;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_lo", 64'(ResultLo), 64'd0);
        chk("rst_hi", 64'(ResultHi), 64'd0);
        chk("rst_flags", 64'(MulDivFlags), 64'd0);
        chk("rst_divzero", 64'(DivZero), 64'd0);
        chk_en = 1'b1;
        @(posedge clk); #2 reset = 1'b0;

        run_op("umull_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 1'b0, N, 1'b0);
        run_op("smull_neg", 2'b01, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 1'b0, N, 1'b0);
        run_op("smull_zero", 2'b01, 32'h00000000, 32'h00001234, 1'b1, 32'h0, 32'h0, 4'b0100, 1'b0, N, 1'b0);
        run_op("sdiv_m7_2", 2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 1'b0, N, 1'b0);
        run_op("sdiv_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 4'b1000, 1'b0, N, 1'b0);
        run_op("sdiv_7_m2", 2'b11, 32'h00000007, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 4'b1000, 1'b0, N, 1'b0);
        run_op("udiv_by0", 2'b10, 32'h00000005, 32'h0, 1'b1, 32'h0, 32'h00000005, 4'b0100, 1'b1, 0, 1'b0);
        run_op("udiv_100_7", 2'b10, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 4'b0000, 1'b0, N, 1'b0);
        run_op("sdiv_by0_flush", 2'b11, 32'hFFFFFFF9, 32'h0, 1'b1, 32'h0, 32'hFFFFFFF9, 4'b0100, 1'b1, 0, 1'b1);
        run_op("umull_mix", 2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, N, 1'b0);
        run_op("smull_mix", 2'b01, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, N, 1'b0);
        run_op("udiv_max", 2'b10, 32'hFFFFFFFF, 32'h00000003, 1'b1, 32'h55555555, 32'h0, 4'b0000, 1'b0, N, 1'b0);

        // Start with simultaneous flush in IDLE must not be accepted.
        @(posedge clk); #2;
        StartE = 1'b1; FlushE = 1'b1; MulDivOpE = 2'b00; a = 32'd3; b = 32'd4;
        @(posedge clk); #2;
        StartE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        chk("start_flush_busy", 64'(Busy), 64'd0);

        // Flush mid-RUN while StartE stays high with other operands.
        run_op("udiv_prev", 2'b10, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 4'b0000, 1'b0, N, 1'b0);
        @(posedge clk); #2;
        StartE = 1'b1; MulDivOpE = 2'b00; a = 32'd3; b = 32'd4;
        @(posedge clk); #2;
        MulDivOpE = 2'b10; a = 32'd50; b = 32'd5;
        repeat (10) @(posedge clk);
        #2 FlushE = 1'b1;
        @(posedge clk); #2;
        FlushE = 1'b0; StartE = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(Busy), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        chk("flush_no_done", 64'(done_cnt), 64'd0);
        chk("flush_keep_lo", 64'(ResultLo), 64'd14);
        chk("flush_keep_hi", 64'(ResultHi), 64'd2);

        // Async reset mid-RUN, with a divide-by-zero result held beforehand.
        run_op("udiv_by0_b", 2'b10, 32'h00000009, 32'h0, 1'b1, 32'h0, 32'h00000009, 4'b0100, 1'b1, 0, 1'b0);
        @(posedge clk); #2;
        StartE = 1'b1; MulDivOpE = 2'b00; a = 32'h00010001; b = 32'h00020002;
        @(posedge clk); #2;
        StartE = 1'b0;
        repeat (15) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_done", 64'(Done), 64'd0);
        chk("arst_divzero", 64'(DivZero), 64'd0);
        chk("arst_lo", 64'(ResultLo), 64'd0);
        chk("arst_hi", 64'(ResultHi), 64'd0);
        chk("arst_flags", 64'(MulDivFlags), 64'd0);
        @(posedge clk); #2 reset = 1'b0;
        run_op("post_rst", 2'b00, 32'h00010001, 32'h00020002, 1'b1, 32'h00040002, 32'h00000002, 4'b0000, 1'b0, N, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
